// File: rtl/rbus_pkg.sv
// Shared rbus definitions: header field positions, op encodings and the initiator state enum.
`default_nettype none

package rbus_pkg;

  localparam int STB    = 71;
  localparam int RECO   = 70;
  localparam int PR_HI  = 69;
  localparam int PR_LO  = 68;
  localparam int TAG_HI = 67;
  localparam int TAG_LO = 40;
  localparam int LEN    = 39;
  localparam int OP_HI  = 1;
  localparam int OP_LO  = 0;

  localparam logic [1:0] RD1 = 2'b00;
  localparam logic [1:0] RD8 = 2'b01;
  localparam logic [1:0] WR  = 2'b10;
  localparam logic [1:0] UPD = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    INSERT    = 2'd2,
    WAIT_RSP  = 2'd3
  } init_state_e;

  function automatic logic needs_feedback(input logic [1:0] op, input logic wr_fb);
    return (op != WR) || wr_fb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rsbus_initiator_buf.sv
// 8x72 payload register file: one synchronous write port, one combinational read port.
`default_nettype none

module rsbus_initiator_buf (
  input  logic        clk,
  input  logic        wr,
  input  logic [2:0]  wr_idx,
  input  logic [71:0] wr_data,
  input  logic [2:0]  rd_idx,
  output logic [71:0] rd_data
);

  logic [71:0] mem [8];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/rsbus_initiator.sv
// rbus request initiator: inserts one request into a free d2r slot and pulls the tagged response off r2d.
`default_nettype none

module rsbus_initiator
  import rbus_pkg::*;
#(
  parameter string SEND_WR_FB  = "TRUE",
  parameter int    RSP_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d2r_i_sof,
  input  logic [11:0] d2r_i_ctrl,
  input  logic [71:0] d2r_i_bus,
  output logic        d2r_o_sof,
  output logic [11:0] d2r_o_ctrl,
  output logic [71:0] d2r_o_bus,
  input  logic        r2d_i_sof,
  input  logic [71:0] r2d_i_bus,
  output logic        r2d_o_sof,
  output logic [71:0] r2d_o_bus,
  input  logic        req_dat_wr,
  input  logic [2:0]  req_dat_idx,
  input  logic [71:0] req_dat,
  input  logic        req_valid,
  input  logic [71:0] req_hdr,
  input  logic [11:0] req_ctrl,
  output logic        req_ack,
  output logic        busy,
  output logic        rsp_sof,
  output logic        rsp_valid,
  output logic [71:0] rsp_data,
  output logic        rsp_err
);

  localparam logic WR_FB = (SEND_WR_FB == "TRUE");

  init_state_e state, state_nxt;
  logic        capt, capt_nxt;
  logic [2:0]  k, k_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [69:0] hdr;
  logic [11:0] ctrl;
  logic [71:0] buf_rd;
  logic [11:0] d2r_ctrl_nxt;
  logic [71:0] d2r_bus_nxt, r2d_bus_nxt;
  logic        ack_nxt, err_nxt, rsp_sof_nxt, rsp_valid_nxt;
  logic        slot_free, rsp_match;
  logic        hdr_flags_unused;

  // Strobe and reco of the request are always regenerated on insertion.
  assign hdr_flags_unused = ^req_hdr[STB:RECO];

  rsbus_initiator_buf u_buf (
    .clk     (clk),
    .wr      (req_dat_wr),
    .wr_idx  (req_dat_idx),
    .wr_data (req_dat),
    .rd_idx  (k),
    .rd_data (buf_rd)
  );

  assign slot_free = d2r_i_sof && !d2r_i_bus[STB] && (d2r_i_bus[LEN] == hdr[LEN]);
  assign rsp_match = r2d_i_sof && r2d_i_bus[STB] && !r2d_i_bus[RECO] &&
                     (r2d_i_bus[TAG_HI:TAG_LO] == hdr[TAG_HI:TAG_LO]);

  always_comb begin
    state_nxt     = state;
    capt_nxt      = capt;
    k_nxt         = k;
    cnt_nxt       = '0;
    d2r_ctrl_nxt  = d2r_i_ctrl;
    d2r_bus_nxt   = d2r_i_bus;
    r2d_bus_nxt   = r2d_i_bus;
    ack_nxt       = 1'b0;
    err_nxt       = 1'b0;
    rsp_sof_nxt   = 1'b0;
    rsp_valid_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) state_nxt = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (slot_free) begin
          state_nxt    = INSERT;
          k_nxt        = 3'd0;
          ack_nxt      = 1'b1;
          d2r_ctrl_nxt = ctrl;
          d2r_bus_nxt  = {1'b1, 1'b0, hdr};
        end
      end
      INSERT: begin
        if (d2r_i_sof) begin
          state_nxt = needs_feedback(hdr[OP_HI:OP_LO], WR_FB) ? WAIT_RSP : IDLE;
        end else begin
          d2r_ctrl_nxt = '0;
          d2r_bus_nxt  = (hdr[LEN] || k == 3'd0) ? buf_rd : '0;
          if (k != 3'd7) k_nxt = k + 3'd1;
        end
      end
      WAIT_RSP: begin
        if (capt) begin
          if (r2d_i_sof) begin
            state_nxt = IDLE;
            capt_nxt  = 1'b0;
          end else begin
            r2d_bus_nxt   = '0;
            rsp_valid_nxt = 1'b1;
          end
        end else if (rsp_match) begin
          // A match in the expiry cycle still wins over the timeout.
          capt_nxt      = 1'b1;
          r2d_bus_nxt   = '0;
          rsp_sof_nxt   = 1'b1;
          rsp_valid_nxt = 1'b1;
        end else if (cnt == 16'(RSP_TIMEOUT - 1)) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      capt       <= 1'b0;
      k          <= '0;
      cnt        <= '0;
      hdr        <= '0;
      ctrl       <= '0;
      d2r_o_sof  <= 1'b0;
      d2r_o_ctrl <= '0;
      d2r_o_bus  <= '0;
      r2d_o_sof  <= 1'b0;
      r2d_o_bus  <= '0;
      req_ack    <= 1'b0;
      busy       <= 1'b0;
      rsp_sof    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      capt       <= capt_nxt;
      k          <= k_nxt;
      cnt        <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        hdr  <= req_hdr[69:0];
        ctrl <= req_ctrl;
      end
      d2r_o_sof  <= d2r_i_sof;
      d2r_o_ctrl <= d2r_ctrl_nxt;
      d2r_o_bus  <= d2r_bus_nxt;
      r2d_o_sof  <= r2d_i_sof;
      r2d_o_bus  <= r2d_bus_nxt;
      req_ack    <= ack_nxt;
      busy       <= (state_nxt == INSERT) || (state_nxt == WAIT_RSP);
      rsp_sof    <= rsp_sof_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_data   <= rsp_valid_nxt ? r2d_i_bus : '0;
      rsp_err    <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rsbus_initiator.sv
// Scoreboard bench for rsbus_initiator (writes without feedback, 16-cycle response timeout).
`default_nettype none

module tb_rsbus_initiator;

  localparam logic [11:0] CIN   = 12'h5A5;
  localparam logic [11:0] RCTRL = 12'h3C3;
  localparam logic [71:0] Z     = 72'h0;
  localparam logic [71:0] X     = 72'h12_3456_789A_BCDE_F012;
  localparam logic [71:0] RD    = 72'hC1_C2C3_C4C5_C6C7_C8C9;
  localparam logic [71:0] W0    = 72'hA5_A5A5_A5A5_A5A5_A5A5;
  localparam logic        L0    = 1'b0;
  localparam logic        L1    = 1'b1;

  function automatic logic [71:0] word(input logic stb, input logic reco, input logic [1:0] pr,
                                       input logic [27:0] tag, input logic len, input logic [38:0] lo);
    return {stb, reco, pr, tag, len, lo};
  endfunction

  function automatic logic [71:0] lw(input int i);
    return 72'hB0_0000_0000_0000_0000 | 72'(i);
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d2r_i_sof = 1'b0;
  logic [11:0] d2r_i_ctrl = '0;
  logic [71:0] d2r_i_bus = '0;
  logic        r2d_i_sof = 1'b0;
  logic [71:0] r2d_i_bus = '0;
  logic        req_dat_wr = 1'b0;
  logic [2:0]  req_dat_idx = '0;
  logic [71:0] req_dat = '0;
  logic        req_valid = 1'b0;
  logic [71:0] req_hdr = '0;
  logic [11:0] req_ctrl = '0;
  logic        d2r_o_sof, r2d_o_sof, req_ack, busy, rsp_sof, rsp_valid, rsp_err;
  logic [11:0] d2r_o_ctrl;
  logic [71:0] d2r_o_bus, r2d_o_bus, rsp_data;

  rsbus_initiator #(.SEND_WR_FB("FALSE"), .RSP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .d2r_i_sof(d2r_i_sof), .d2r_i_ctrl(d2r_i_ctrl), .d2r_i_bus(d2r_i_bus),
    .d2r_o_sof(d2r_o_sof), .d2r_o_ctrl(d2r_o_ctrl), .d2r_o_bus(d2r_o_bus),
    .r2d_i_sof(r2d_i_sof), .r2d_i_bus(r2d_i_bus),
    .r2d_o_sof(r2d_o_sof), .r2d_o_bus(r2d_o_bus),
    .req_dat_wr(req_dat_wr), .req_dat_idx(req_dat_idx), .req_dat(req_dat),
    .req_valid(req_valid), .req_hdr(req_hdr), .req_ctrl(req_ctrl),
    .req_ack(req_ack), .busy(busy),
    .rsp_sof(rsp_sof), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dsof;
    logic [11:0] dctrl;
    logic [71:0] dbus;
    logic        rsof;
    logic [71:0] rbus;
    logic        ack;
    logic        bsy;
    logic        err;
    logic        rv;
  } exp_t;

  typedef struct packed {
    logic        sof;
    logic [71:0] data;
  } rsp_t;

  exp_t  exp_q[$];
  rsp_t  rsp_q[$];
  int    total = 0;
  int    bad = 0;
  string tname = "reset";

  // Monitor: every registered cycle is compared to the queued expectation; response words on rsp_valid.
  always @(negedge clk) begin
    exp_t e, a;
    rsp_t r;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {d2r_o_sof, d2r_o_ctrl, d2r_o_bus, r2d_o_sof, r2d_o_bus, req_ack, busy, rsp_err, rsp_valid};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s cycle: got %h want %h", tname, a, e);
        end
      end
      if (rsp_valid) begin
        total++;
        if (rsp_q.size() == 0) begin
          bad++;
          $display("FAIL %s rsp_word: got sof=%0b data=%h want none", tname, rsp_sof, rsp_data);
        end else begin
          r = rsp_q.pop_front();
          if ({rsp_sof, rsp_data} !== r) begin
            bad++;
            $display("FAIL %s rsp_word: got sof=%0b data=%h want sof=%0b data=%h",
                     tname, rsp_sof, rsp_data, r.sof, r.data);
          end
        end
      end
    end
  end

  // md: 0 pass-through, 1 inserted header (latched ctrl), 2 inserted payload (zero ctrl). mr: r2d word zeroed.
  task automatic cyc(input logic ds, input logic [71:0] db, input logic rs, input logic [71:0] rb,
                     input int md, input logic [71:0] ed, input logic mr,
                     input logic ack, input logic bsy, input logic err, input logic rv, input logic rsf);
    exp_t e;
    rsp_t r;
    d2r_i_sof  = ds;
    d2r_i_bus  = db;
    d2r_i_ctrl = CIN;
    r2d_i_sof  = rs;
    r2d_i_bus  = rb;
    e.dsof  = ds;
    e.dctrl = (md == 0) ? CIN : ((md == 1) ? RCTRL : 12'h000);
    e.dbus  = (md == 0) ? db : ed;
    e.rsof  = rs;
    e.rbus  = mr ? Z : rb;
    e.ack   = ack;
    e.bsy   = bsy;
    e.err   = err;
    e.rv    = rv;
    @(posedge clk);
    exp_q.push_back(e);
    if (rv) begin
      r.sof  = rsf;
      r.data = rb;
      rsp_q.push_back(r);
    end
    #1;
  endtask

  task automatic pass(input logic ds, input logic [71:0] db, input logic rs, input logic [71:0] rb, input logic bsy);
    cyc(ds, db, rs, rb, 0, Z, L0, L0, bsy, L0, L0, L0);
  endtask

  task automatic idle(input int n, input logic bsy);
    for (int i = 0; i < n; i++) pass(L0, X, L0, Z, bsy);
  endtask

  task automatic wr_buf(input int idx, input logic [71:0] v);
    req_dat_wr  = 1'b1;
    req_dat_idx = 3'(idx);
    req_dat     = v;
    idle(1, L0);
    req_dat_wr  = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    logic [234:0] a;
    a = {d2r_o_sof, d2r_o_ctrl, d2r_o_bus, r2d_o_sof, r2d_o_bus, req_ack, busy,
         rsp_sof, rsp_valid, rsp_data, rsp_err};
    total++;
    if (a !== '0) begin
      bad++;
      $display("FAIL %s outputs: got %h want 0", nm, a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] occ, fs, fl, fr;
    logic [71:0] h1, eh1, rsp1, h2, eh2, h3, eh3, h4, eh4, rsp4, h5, eh5, h6, eh6, rsp6;
    occ  = word(L1, L0, 2'b11, 28'hFFF0001, L0, 39'h12345);
    fs   = word(L0, L0, 2'b00, 28'h0, L0, 39'h0);
    fl   = word(L0, L0, 2'b00, 28'h0, L1, 39'h0);
    fr   = word(L1, L0, 2'b01, 28'h0000ABC, L0, 39'h0);
    h1   = word(L0, L1, 2'b01, 28'h0000123, L0, 39'h0);
    eh1  = word(L1, L0, 2'b01, 28'h0000123, L0, 39'h0);
    rsp1 = word(L1, L0, 2'b01, 28'h0000123, L0, 39'h55);
    h2   = word(L0, L0, 2'b10, 28'h0000456, L1, 39'h2);
    eh2  = word(L1, L0, 2'b10, 28'h0000456, L1, 39'h2);
    h3   = word(L0, L0, 2'b00, 28'h0000777, L0, 39'h1);
    eh3  = word(L1, L0, 2'b00, 28'h0000777, L0, 39'h1);
    h4   = word(L0, L0, 2'b00, 28'h0000778, L0, 39'h0);
    eh4  = word(L1, L0, 2'b00, 28'h0000778, L0, 39'h0);
    rsp4 = word(L1, L0, 2'b00, 28'h0000778, L0, 39'h7);
    h5   = word(L0, L0, 2'b11, 28'h0000999, L1, 39'h0);
    eh5  = word(L1, L0, 2'b11, 28'h0000999, L1, 39'h0);
    h6   = word(L0, L0, 2'b00, 28'h0000321, L0, 39'h0);
    eh6  = word(L1, L0, 2'b00, 28'h0000321, L0, 39'h0);
    rsp6 = word(L1, L0, 2'b00, 28'h0000321, L0, 39'h9);
    req_ctrl = RCTRL;

    #3 chk_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Short read, foreign response ignored, early matching header not consumed.
    tname = "short_read";
    wr_buf(0, W0);
    req_valid = 1'b1; req_hdr = h1;
    idle(1, L0);
    pass(L1, occ, L1, rsp1, L0);
    pass(L0, X, L0, RD, L0);
    cyc(L1, fs, L0, Z, 1, eh1, L0, L1, L1, L0, L0, L0);
    req_valid = 1'b0;
    cyc(L0, X, L0, Z, 2, W0, L0, L0, L1, L0, L0, L0);
    cyc(L0, X, L0, Z, 2, Z, L0, L0, L1, L0, L0, L0);
    pass(L1, occ, L0, Z, L1);
    pass(L0, Z, L1, fr, L1);
    pass(L0, Z, L0, RD, L1);
    cyc(L0, Z, L1, rsp1, 0, Z, L1, L0, L1, L0, L1, L1);
    cyc(L0, Z, L0, RD, 0, Z, L1, L0, L1, L0, L1, L0);
    pass(L0, Z, L1, fr, L0);
    idle(1, L0);

    // Long write without feedback, skipping three short free slots.
    tname = "long_write";
    for (int i = 0; i < 8; i++) wr_buf(i, lw(i));
    req_valid = 1'b1; req_hdr = h2;
    idle(1, L0);
    pass(L1, fs, L0, Z, L0);
    pass(L0, X, L0, Z, L0);
    pass(L1, fs, L0, Z, L0);
    pass(L1, fs, L0, Z, L0);
    cyc(L1, fl, L0, Z, 1, eh2, L0, L1, L1, L0, L0, L0);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) cyc(L0, X, L0, Z, 2, lw(i), L0, L0, L1, L0, L0, L0);
    cyc(L0, X, L0, Z, 2, lw(7), L0, L0, L1, L0, L0, L0);
    pass(L1, occ, L0, Z, L0);
    idle(20, L0);

    // Timeout with no response.
    tname = "timeout";
    req_valid = 1'b1; req_hdr = h3;
    idle(1, L0);
    cyc(L1, fs, L0, Z, 1, eh3, L0, L1, L1, L0, L0, L0);
    req_valid = 1'b0;
    cyc(L0, X, L0, Z, 2, lw(0), L0, L0, L1, L0, L0, L0);
    pass(L1, occ, L0, Z, L1);
    idle(15, L1);
    cyc(L0, X, L0, Z, 0, Z, L0, L0, L0, L1, L0, L0);
    idle(2, L0);

    // Response arriving in the expiry cycle wins.
    tname = "late_match";
    req_valid = 1'b1; req_hdr = h4;
    idle(1, L0);
    cyc(L1, fs, L0, Z, 1, eh4, L0, L1, L1, L0, L0, L0);
    req_valid = 1'b0;
    cyc(L0, X, L0, Z, 2, lw(0), L0, L0, L1, L0, L0, L0);
    pass(L1, occ, L0, Z, L1);
    idle(15, L1);
    cyc(L0, Z, L1, rsp4, 0, Z, L1, L0, L1, L0, L1, L1);
    cyc(L0, Z, L0, RD, 0, Z, L1, L0, L1, L0, L1, L0);
    pass(L0, Z, L1, fr, L0);
    idle(3, L0);

    // Reset during long insertion, then a fresh request.
    tname = "reset_insert";
    req_valid = 1'b1; req_hdr = h5;
    idle(1, L0);
    cyc(L1, fl, L0, Z, 1, eh5, L0, L1, L1, L0, L0, L0);
    req_valid = 1'b0;
    cyc(L0, X, L0, Z, 2, lw(0), L0, L0, L1, L0, L0, L0);
    cyc(L0, X, L0, Z, 2, lw(1), L0, L0, L1, L0, L0, L0);
    @(negedge clk);
    #1 rst = 1'b1;
    d2r_i_sof = 1'b0; d2r_i_bus = X; r2d_i_sof = 1'b1; r2d_i_bus = rsp1;
    #1 chk_zero("reset_async");
    repeat (2) begin
      @(negedge clk);
      chk_zero("reset_hold");
    end
    #1 rst = 1'b0;
    tname = "after_reset";
    req_valid = 1'b1; req_hdr = h6;
    idle(1, L0);
    cyc(L1, fs, L0, Z, 1, eh6, L0, L1, L1, L0, L0, L0);
    req_valid = 1'b0;
    cyc(L0, X, L0, Z, 2, lw(0), L0, L0, L1, L0, L0, L0);
    pass(L1, occ, L0, Z, L1);
    cyc(L0, Z, L1, rsp6, 0, Z, L1, L0, L1, L0, L1, L1);
    pass(L0, Z, L1, fr, L0);
    idle(3, L0);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got exp=%0d rsp=%0d pending want 0", exp_q.size(), rsp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rsbus_initiator.md
# rsbus_initiator

Request-originating endpoint on the rbus dual ring, the counterpart of a responder/devnull node. It takes one local memory request (header plus up to 8 payload words) and inserts it into the first free d2r slot of matching length. It then watches the r2d ring for the response carrying the same tag, removes it from the ring and streams it to the local side. One request is outstanding at a time, with a response timeout.

## Interface
Parameters:
- SEND_WR_FB, "TRUE": "TRUE" means writes (op 2'b10) expect a response; "FALSE" means writes complete at insertion.
- RSP_TIMEOUT, 1024: cycles to wait for a response before an error is flagged; legal range 2..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- d2r_i_sof / d2r_i_ctrl / d2r_i_bus  in  1/12/72  upstream d2r ring
- d2r_o_sof / d2r_o_ctrl / d2r_o_bus  out  1/12/72  downstream d2r ring
- r2d_i_sof / r2d_i_bus  in  1/72  upstream r2d ring
- r2d_o_sof / r2d_o_bus  out  1/72  downstream r2d ring
- req_dat_wr  in  1  writes req_dat into payload buffer at req_dat_idx
- req_dat_idx  in  3  payload word index
- req_dat  in  72  payload word
- req_valid  in  1  request pending; must be held until req_ack
- req_hdr  in  72  header: [69:68] priority, [67:40] tag/address, [39] length (0 short, 1 long), [1:0] op
- req_ctrl  in  12  ctrl word driven with the header
- req_ack  out  1  one-cycle pulse when the header is inserted
- busy  out  1  high from insertion until response, timeout or no-feedback completion
- rsp_sof  out  1  first word (header) of the response
- rsp_valid  out  1  response word present
- rsp_data  out  72  response word
- rsp_err  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE, WAIT_SLOT, INSERT, WAIT_RSP.
- IDLE:
  - req_valid moves to WAIT_SLOT and latches req_hdr/req_ctrl.
  - The payload buffer is writable in every state, but a write is only safe before req_valid.
- WAIT_SLOT, free slot test:
  - Condition: d2r_i_sof & !d2r_i_bus[71] & (d2r_i_bus[39]==hdr[39]).
  - On a free slot: drive the header with [71]=1 and [70]=0 (reco). All other bits come from the latch. Pulse req_ack and go to INSERT.
- INSERT:
  - Each non-sof cycle drives buf[k], k=0,1,… (k saturates at 7).
  - Short frames drive buf[0] only, then zero words.
  - The next d2r_i_sof ends INSERT.
  - Next state is WAIT_RSP if op is rd1/rd8/upda, or wr with SEND_WR_FB=="TRUE". Otherwise it is IDLE.
- Non-inserted d2r words pass through unchanged with one register stage.
- WAIT_RSP, matching response:
  - Condition: r2d_i_sof & r2d_i_bus[71] & !r2d_i_bus[70] & (r2d_i_bus[67:40]==hdr[67:40]).
  - That header and every word up to the next r2d_i_sof are copied to rsp_* (rsp_sof on the header).
  - The same words are driven as all-zero on r2d_o_bus (slot freed).
  - Return to IDLE at the next r2d_i_sof.
- Non-matching r2d traffic passes through with one register stage.
- Timeout counter:
  - Counts the cycles spent in WAIT_RSP.
  - Reaching RSP_TIMEOUT pulses rsp_err and returns to IDLE.
  - If a match and expiry occur in the same cycle, the match wins and no rsp_err is raised.
- Edge cases:
  - A matching header seen in IDLE/WAIT_SLOT/INSERT is passed through and not consumed.
  - Priority is echoed, not arbitrated.

## Timing
- d2r and r2d paths: 1-cycle latency; the sof outputs are the inputs delayed by one cycle.
- req_ack: asserted in the cycle after the free-slot sof, aligned with d2r_o_sof of the inserted header.
- Earliest re-accept: req_valid is sampled again the cycle after IDLE is re-entered.
- Response path: rsp_valid/rsp_data are aligned with the corresponding (zeroed) r2d_o word. rsp_valid drops the cycle after the last word.
- Reset:
  - Every output is 0, including both buses and both ctrl fields.
  - State goes to IDLE, and counter and k go to 0.
  - The payload buffer is not reset.
- Reset mid-insertion: the partially inserted slot is truncated, and downstream sees zeros for the reset cycles.

## Structure
- rbus_pkg holds:
  - header field constants (STB=71, RECO=70, PR=69:68, TAG=67:40, LEN=39, OP=1:0);
  - op encodings (RD1, RD8, WR, UPD);
  - a state enum for this block.
- Sub-module rsbus_initiator_buf: an 8×72 register-file payload buffer with a write port and a combinational read port.

## Test plan
- Short read: hdr op=00, tag=0x0000123, len=0. Slot 1 is occupied, slot 2 is free and short. Expect req_ack in the cycle after the slot-2 sof, and d2r_o header [71]=1, [70]=0. Then a response with tag 0x0000123 arrives: rsp_sof=1 with 2 words out, r2d_o zeros for those words, busy drops.
- Long write, SEND_WR_FB="FALSE": buf=0..7, len=1, a long free slot arrives. d2r_o carries header then 1..7,… pattern order buf[0]..buf[7]. State returns to IDLE with no WAIT_RSP.
- Length mismatch: long request, 3 free short slots then 1 free long slot. Insertion happens only in the long slot; short slots pass through unchanged.
- Foreign response: a tag 0xABC response arrives while awaiting 0x123. It passes through unchanged and rsp_valid stays 0.
- Timeout: RSP_TIMEOUT=16 with no response. rsp_err pulses exactly 16 cycles after WAIT_RSP entry. A response on cycle 16 yields data and no rsp_err.
- Reset during INSERT of a long frame: all outputs read 0 and state is IDLE. A new request is then accepted normally.
